handoff_sequencer: RTL and testbench

HANDOFF_SEQUENCER -- requirements
Module: handoff_sequencer

---
 rtl/handoff_sequencer.sv | 100 ++++++++++
 tb/tb_handoff_sequencer.sv | 125 ++++++++++++
 2 files changed

// File: rtl/handoff_sequencer.sv
// handoff_sequencer: two-player turn/handoff game sequencer counting completed rounds.
// Define HANDOFF_TIMEOUT_EN to add the forced-handoff turn timer and timeout_pulse.
module handoff_sequencer #(
    parameter int TURN_CYCLES = 100,
    parameter int MAX_ROUNDS  = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       p1_btn,
    input  logic       p2_btn,
    output logic [3:0] state,
    output logic       p1handed,
    output logic       p2handed,
    output logic [3:0] round,
    output logic       busy,
    output logic       timeout_pulse
);
    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        P1_TURN = 4'd1,
        P1_HAND = 4'd2,
        P2_TURN = 4'd3,
        P2_HAND = 4'd4,
        DONE    = 4'd5
    } state_t;

    localparam logic [3:0] LAST_ROUND = 4'(MAX_ROUNDS);

    state_t     cur, nxt;
    logic [3:0] round_nxt;
    logic       p1_q, p2_q, p1_press, p2_press, expired;

    // Only a fresh rising edge counts, so a button held across a handoff is ignored.
    assign p1_press = p1_btn & ~p1_q;
    assign p2_press = p2_btn & ~p2_q;

    assign state    = cur;
    assign p1handed = cur == P1_HAND;
    assign p2handed = cur == P2_HAND;
    assign busy     = cur != IDLE && cur != DONE;

    always_ff @(posedge clk) begin
        if (reset) begin
            cur   <= IDLE;
            round <= '0;
            p1_q  <= 1'b0;
            p2_q  <= 1'b0;
        end else begin
            cur   <= nxt;
            round <= round_nxt;
            p1_q  <= p1_btn;
            p2_q  <= p2_btn;
        end
    end

    always_comb begin
        nxt       = cur;
        round_nxt = round;
        case (cur)
            IDLE, DONE: begin
                nxt       = start ? P1_TURN : cur;
                round_nxt = start ? 4'd0 : round;
            end
            P1_TURN: nxt = (p1_press || expired) ? P1_HAND : P1_TURN;
            P1_HAND: nxt = P2_TURN;
            P2_TURN: nxt = (p2_press || expired) ? P2_HAND : P2_TURN;
            P2_HAND: begin
                round_nxt = round + 4'd1;
                nxt       = (round_nxt == LAST_ROUND) ? DONE : P1_TURN;
            end
            default: begin
                nxt       = IDLE;
                round_nxt = '0;
            end
        endcase
    end

`ifdef HANDOFF_TIMEOUT_EN
    localparam logic [15:0] TIMER_LAST = 16'(TURN_CYCLES - 1);
    logic [15:0] timer;

    assign expired = timer == TIMER_LAST;

    // Timer restarts from zero whenever a turn state is (re)entered.
    always_ff @(posedge clk) begin
        if (reset) begin
            timer         <= '0;
            timeout_pulse <= 1'b0;
        end else begin
            timer         <= ((cur == P1_TURN || cur == P2_TURN) && nxt == cur) ? timer + 16'd1 : 16'd0;
            timeout_pulse <= expired && ((cur == P1_TURN && !p1_press) || (cur == P2_TURN && !p2_press));
        end
    end
`else
    assign expired       = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_handoff_sequencer.sv
// tb_handoff_sequencer: table-driven directed vectors for handoff_sequencer (TURN_CYCLES=4, MAX_ROUNDS=2).
module tb_handoff_sequencer;
    logic       clk = 1'b0;
    logic       reset = 1'b0, start = 1'b0, p1_btn = 1'b0, p2_btn = 1'b0;
    logic [3:0] state, round;
    logic       p1handed, p2handed, busy, timeout_pulse;
    int         vectors = 0;
    int         miscompares = 0;

    typedef struct {
        logic       rst, st, b1, b2;
        logic [3:0] es, er;
    } vec_t;

    vec_t tbl[$];

    handoff_sequencer #(.TURN_CYCLES(4), .MAX_ROUNDS(2)) dut (
        .clk(clk), .reset(reset), .start(start), .p1_btn(p1_btn), .p2_btn(p2_btn),
        .state(state), .p1handed(p1handed), .p2handed(p2handed), .round(round),
        .busy(busy), .timeout_pulse(timeout_pulse)
    );

    always #5 clk = ~clk;

    function automatic vec_t v(int r, int s, int a, int b, int e, int rr);
        vec_t x;
        x.rst = 1'(r);
        x.st  = 1'(s);
        x.b1  = 1'(a);
        x.b2  = 1'(b);
        x.es  = 4'(e);
        x.er  = 4'(rr);
        return x;
    endfunction

    task automatic check(input string name, input logic [3:0] es, input logic [3:0] er, input logic ep);
        logic eb, e1, e2;
        eb = !(es == 4'd0 || es == 4'd5);
        e1 = es == 4'd2;
        e2 = es == 4'd4;
        vectors++;
        if (state !== es || round !== er || busy !== eb || p1handed !== e1 || p2handed !== e2 || timeout_pulse !== ep) begin
            miscompares++;
            $display("FAIL %s: got state=%b round=%0d busy=%b p1h=%b p2h=%b tp=%b, want state=%b round=%0d busy=%b p1h=%b p2h=%b tp=%b",
                     name, state, round, busy, p1handed, p2handed, timeout_pulse, es, er, eb, e1, e2, ep);
        end
    endtask

    task automatic step(input logic r, input logic s, input logic a, input logic b);
        @(negedge clk);
        reset = r; start = s; p1_btn = a; p2_btn = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        tbl.push_back(v(1,0,0,0, 0,0));  // reset
        tbl.push_back(v(1,1,0,0, 0,0));  // reset beats start
        tbl.push_back(v(0,0,0,0, 0,0));  // hold IDLE
        tbl.push_back(v(0,1,0,0, 1,0));  // start -> P1_TURN
        tbl.push_back(v(0,0,0,1, 1,0));  // p2 press ignored in P1_TURN
        tbl.push_back(v(0,0,0,0, 1,0));
        tbl.push_back(v(0,0,1,0, 2,0));  // p1 press -> P1_HAND
        tbl.push_back(v(0,0,0,0, 3,0));  // -> P2_TURN
        tbl.push_back(v(0,0,1,0, 3,0));  // p1 press ignored in P2_TURN
        tbl.push_back(v(0,0,0,0, 3,0));
        tbl.push_back(v(0,0,0,1, 4,0));  // p2 press -> P2_HAND
        tbl.push_back(v(0,0,0,0, 1,1));  // round 1
        tbl.push_back(v(0,0,1,0, 2,1));
        tbl.push_back(v(0,0,0,0, 3,1));
        tbl.push_back(v(0,0,0,1, 4,1));
        tbl.push_back(v(0,0,0,0, 5,2));  // DONE
        tbl.push_back(v(0,0,0,0, 5,2));  // hold DONE
        tbl.push_back(v(0,1,0,0, 1,0));  // restart
        tbl.push_back(v(0,1,0,0, 1,0));  // start ignored while busy
        tbl.push_back(v(0,0,1,0, 2,0));  // p1 held from here
        tbl.push_back(v(0,0,1,0, 3,0));
        tbl.push_back(v(0,0,1,0, 3,0));
        tbl.push_back(v(0,0,1,1, 4,0));
        tbl.push_back(v(0,0,1,0, 1,1));
        tbl.push_back(v(0,0,1,0, 1,1));  // still held: no handoff
        tbl.push_back(v(0,0,0,0, 1,1));  // release
        tbl.push_back(v(0,0,1,0, 2,1));  // re-press
        tbl.push_back(v(1,0,0,0, 0,0));  // reset mid-handoff
        tbl.push_back(v(0,1,0,0, 1,0));
        tbl.push_back(v(0,0,1,1, 2,0));  // both rise: p1 honoured
        tbl.push_back(v(0,0,0,0, 3,0));
        tbl.push_back(v(0,0,1,1, 4,0));  // both rise: p2 honoured
        tbl.push_back(v(0,0,0,0, 1,1));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].st, tbl[i].b1, tbl[i].b2);
            check($sformatf("vec%0d", i), tbl[i].es, tbl[i].er, 1'b0);
        end

`ifdef HANDOFF_TIMEOUT_EN
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check($sformatf("p1_wait%0d", i), 4'd1, 4'd1, 1'b0);
        end
        step(0, 0, 0, 0);
        check("p1_timeout", 4'd2, 4'd1, 1'b1);
        step(0, 0, 0, 0);
        check("p1_timeout_clear", 4'd3, 4'd1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0);
            check($sformatf("p2_wait%0d", i), 4'd3, 4'd1, 1'b0);
        end
        step(0, 0, 0, 1);
        check("p2_press_beats_timeout", 4'd4, 4'd1, 1'b0);
        step(0, 0, 0, 0);
        check("done_after_timeout_game", 4'd5, 4'd2, 1'b0);
`else
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 0, 0);
            check($sformatf("p1_wait%0d", i), 4'd1, 4'd1, 1'b0);
        end
        step(0, 0, 1, 0);
        check("late_p1_press", 4'd2, 4'd1, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
